// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolve bus of branch_predict_unit.
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] fetchPC;
  logic             predictTaken;
  logic [WIDTH-1:0] predictTarget;
  logic             resolveValid;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] Da;
  logic [WIDTH-1:0] Db;
  logic [WIDTH-1:0] resolvePC;
  logic [WIDTH-1:0] branchTarget;
  logic             predictedTaken;
  logic             mispredict;
  logic [WIDTH-1:0] redirectPC;
  logic             branchTaken;
  logic [31:0]      branchCount;
  logic [31:0]      mispredictCount;

  modport master (
    output fetchPC, resolveValid, opcode, Da, Db, resolvePC, branchTarget, predictedTaken,
    input  predictTaken, predictTarget, mispredict, redirectPC, branchTaken,
           branchCount, mispredictCount
  );

  modport slave (
    input  fetchPC, resolveValid, opcode, Da, Db, resolvePC, branchTarget, predictedTaken,
    output predictTaken, predictTarget, mispredict, redirectPC, branchTaken,
           branchCount, mispredictCount
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolution (BEQ/BNE/BLEZ/BGTZ) plus direct-mapped saturating-counter predictor.
// Optional macro BRANCH_STATS_EN builds saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int WIDTH        = 32,
  parameter int INDEX_BITS   = 4,
  parameter int COUNTER_BITS = 2
) (
  input logic                  clk,
  input logic                  resetN,
  branch_predict_unit_if.slave bus
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef logic [COUNTER_BITS-1:0] cnt_t;
  typedef logic [INDEX_BITS-1:0]   idx_t;

  typedef enum logic [5:0] {
    OP_BEQ  = 6'b000100,
    OP_BNE  = 6'b000101,
    OP_BLEZ = 6'b000110,
    OP_BGTZ = 6'b000111
  } op_e;

  localparam cnt_t CNT_RESET   = cnt_t'(1);
  localparam cnt_t CNT_MAX     = '1;
  localparam cnt_t CNT_WEAK_T  = cnt_t'(1 << (COUNTER_BITS - 1));
  localparam cnt_t CNT_WEAK_NT = cnt_t'((1 << (COUNTER_BITS - 1)) - 1);

  logic             r_valid [DEPTH];
  cnt_t             r_cnt   [DEPTH];
  logic [WIDTH-1:0] r_tgt   [DEPTH];

  logic             r_mispredict;
  logic [WIDTH-1:0] r_redirect;
  logic             r_taken;

  idx_t             w_fetch_idx;
  idx_t             w_res_idx;
  logic             w_is_branch;
  logic             w_cond;
  logic             w_taken;
  logic             w_mispredict;
  logic             w_update;
  logic [WIDTH-1:0] w_next_pc;
  cnt_t             w_cnt_cur;
  cnt_t             w_cnt_next;
  logic             w_unused_fetch_bits;

  // Fetch lookup reads the flops directly, so a same-cycle update is seen only next cycle.
  assign w_fetch_idx       = bus.fetchPC[INDEX_BITS+1:2];
  assign bus.predictTaken  = r_valid[w_fetch_idx] & r_cnt[w_fetch_idx][COUNTER_BITS-1];
  assign bus.predictTarget = bus.predictTaken ? r_tgt[w_fetch_idx] : '0;

  assign w_unused_fetch_bits = ^{bus.fetchPC[WIDTH-1:INDEX_BITS+2], bus.fetchPC[1:0]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_is_branch = 1'b1;
    w_cond      = 1'b0;
    case (bus.opcode)
      OP_BEQ:  w_cond = (bus.Da == bus.Db);
      OP_BNE:  w_cond = (bus.Da != bus.Db);
      OP_BLEZ: w_cond = ($signed(bus.Da) <= $signed(WIDTH'(0)));
      OP_BGTZ: w_cond = ($signed(bus.Da) >  $signed(WIDTH'(0)));
      default: w_is_branch = 1'b0;
    endcase
  end

  assign w_taken      = w_is_branch & w_cond;
  assign w_next_pc    = w_taken ? bus.branchTarget : bus.resolvePC + WIDTH'(4);
  assign w_mispredict = bus.resolveValid & (w_taken != bus.predictedTaken);
  assign w_update     = bus.resolveValid & w_is_branch;
  assign w_res_idx    = bus.resolvePC[INDEX_BITS+1:2];

  // Next state of the 2-bit (generally N-bit) saturating counter being resolved.
  always_comb begin
    w_cnt_cur  = r_cnt[w_res_idx];
    w_cnt_next = w_cnt_cur;
    if (!r_valid[w_res_idx]) begin
      w_cnt_next = w_taken ? CNT_WEAK_T : CNT_WEAK_NT;
    end else if (w_taken) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + cnt_t'(1);
    end else begin
      if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - cnt_t'(1);
    end
  end

  // NOTE: the table is plain flops with async reset so every prediction clears at once;
  // a RAM macro could not be reset this way.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_RESET;
        r_tgt[i]   <= '0;
      end
    end else if (w_update) begin
      r_valid[w_res_idx] <= 1'b1;
      r_cnt[w_res_idx]   <= w_cnt_next;
      r_tgt[w_res_idx]   <= bus.branchTarget;
    end
  end

  // NOTE: state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
      r_taken      <= 1'b0;
    end else begin
      r_mispredict <= w_mispredict;
      r_redirect   <= w_mispredict ? w_next_pc : '0;
      r_taken      <= bus.resolveValid & w_taken;
    end
  end

  assign bus.mispredict  = r_mispredict;
  assign bus.redirectPC  = r_redirect;
  assign bus.branchTaken = r_taken;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispredict_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_update && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign bus.branchCount     = r_branch_cnt;
  assign bus.mispredictCount = r_mispredict_cnt;
`else
  assign bus.branchCount     = '0;
  assign bus.mispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default and BRANCH_STATS_EN builds).
module tb_branch_predict_unit;

  localparam int W = 32;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_RTYP = 6'b000000;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.WIDTH(W)) bus ();

  branch_predict_unit #(.WIDTH(W), .INDEX_BITS(4), .COUNTER_BITS(2)) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  // One resolve plus the fetch address to look at after the edge, with expected results.
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pt;
    logic        mp;
    logic        tk;
    logic [31:0] rd;
    logic [31:0] fpc;
    logic        ptk;
    logic [31:0] ptgt;
  } vec_t;

  task automatic drive(input vec_t v);
    @(negedge clk);
    bus.resolveValid   = 1'b1;
    bus.opcode         = v.op;
    bus.Da             = v.da;
    bus.Db             = v.db;
    bus.resolvePC      = v.pc;
    bus.branchTarget   = v.tgt;
    bus.predictedTaken = v.pt;
    bus.fetchPC        = v.fpc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.resolveValid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.fetchPC = 32'h40; bus.resolveValid = 1'b1; bus.opcode = OP_BEQ;
    bus.Da = 32'd5; bus.Db = 32'd5; bus.resolvePC = 32'h40; bus.branchTarget = 32'h100;
    bus.predictedTaken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests += 7;
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL reset predictTaken got %b want 0", bus.predictTaken); end
    if (bus.predictTarget !== 32'h0) begin n_fail++; $display("FAIL reset predictTarget got %h want 0", bus.predictTarget); end
    if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL reset mispredict got %b want 0", bus.mispredict); end
    if (bus.redirectPC !== 32'h0) begin n_fail++; $display("FAIL reset redirectPC got %h want 0", bus.redirectPC); end
    if (bus.branchTaken !== 1'b0) begin n_fail++; $display("FAIL reset branchTaken got %b want 0", bus.branchTaken); end
    if (bus.branchCount !== 32'h0) begin n_fail++; $display("FAIL reset branchCount got %0d want 0", bus.branchCount); end
    if (bus.mispredictCount !== 32'h0) begin n_fail++; $display("FAIL reset mispredictCount got %0d want 0", bus.mispredictCount); end
    @(negedge clk);
    resetN = 1'b1;
    bus.resolveValid = 1'b0;
    @(posedge clk);
    #1;
    n_tests += 2;
    if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_release mispredict got %b want 0", bus.mispredict); end
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL reset_release predictTaken got %b want 0", bus.predictTaken); end
  endtask

  // Index 0 (PC 0x40): allocate, saturate at 3, then walk down.
  task automatic test_beq_counter();
    vec_t vs [6];
    vs[0] = '{OP_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 32'h40, 1'b1, 32'h100};
    vs[1] = '{OP_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h0,   32'h40, 1'b1, 32'h100};
    vs[2] = '{OP_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h0,   32'h40, 1'b1, 32'h100};
    vs[3] = '{OP_BEQ, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 1'b0, 1'b1, 32'h0,   32'h40, 1'b1, 32'h100};
    vs[4] = '{OP_BNE, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 1'b1, 1'b0, 32'h44,  32'h40, 1'b1, 32'h100};
    vs[5] = '{OP_BNE, 32'd5, 32'd5, 32'h40, 32'h100, 1'b1, 1'b1, 1'b0, 32'h44,  32'h40, 1'b0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive(vs[i]);
      n_tests += 5;
      if (bus.mispredict !== vs[i].mp) begin n_fail++; $display("FAIL beq[%0d] mispredict got %b want %b", i, bus.mispredict, vs[i].mp); end
      if (bus.branchTaken !== vs[i].tk) begin n_fail++; $display("FAIL beq[%0d] branchTaken got %b want %b", i, bus.branchTaken, vs[i].tk); end
      if (bus.redirectPC !== vs[i].rd) begin n_fail++; $display("FAIL beq[%0d] redirectPC got %h want %h", i, bus.redirectPC, vs[i].rd); end
      if (bus.predictTaken !== vs[i].ptk) begin n_fail++; $display("FAIL beq[%0d] predictTaken got %b want %b", i, bus.predictTaken, vs[i].ptk); end
      if (bus.predictTarget !== vs[i].ptgt) begin n_fail++; $display("FAIL beq[%0d] predictTarget got %h want %h", i, bus.predictTarget, vs[i].ptgt); end
    end
  endtask

  // PC 0x80 aliases index 0 (counter 1 on entry); signed BLEZ/BGTZ boundaries.
  task automatic test_signed();
    vec_t vs [6];
    vs[0] = '{OP_BLEZ, 32'hFFFF_FFFF, 32'h123, 32'h80, 32'h300, 1'b0, 1'b1, 1'b1, 32'h300, 32'h40, 1'b1, 32'h300};
    vs[1] = '{OP_BGTZ, 32'h0,         32'h123, 32'h80, 32'h400, 1'b1, 1'b1, 1'b0, 32'h84,  32'h40, 1'b0, 32'h0};
    vs[2] = '{OP_BGTZ, 32'h8000_0000, 32'h123, 32'h80, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0,   32'h40, 1'b0, 32'h0};
    vs[3] = '{OP_BLEZ, 32'h1,         32'h123, 32'h80, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0,   32'h40, 1'b0, 32'h0};
    vs[4] = '{OP_BGTZ, 32'h1,         32'h0,   32'h80, 32'h500, 1'b0, 1'b1, 1'b1, 32'h500, 32'h40, 1'b0, 32'h0};
    vs[5] = '{OP_BLEZ, 32'h0,         32'h123, 32'h80, 32'h500, 1'b1, 1'b0, 1'b1, 32'h0,   32'h40, 1'b1, 32'h500};
    for (int i = 0; i < 6; i++) begin
      drive(vs[i]);
      n_tests += 5;
      if (bus.mispredict !== vs[i].mp) begin n_fail++; $display("FAIL signed[%0d] mispredict got %b want %b", i, bus.mispredict, vs[i].mp); end
      if (bus.branchTaken !== vs[i].tk) begin n_fail++; $display("FAIL signed[%0d] branchTaken got %b want %b", i, bus.branchTaken, vs[i].tk); end
      if (bus.redirectPC !== vs[i].rd) begin n_fail++; $display("FAIL signed[%0d] redirectPC got %h want %h", i, bus.redirectPC, vs[i].rd); end
      if (bus.predictTaken !== vs[i].ptk) begin n_fail++; $display("FAIL signed[%0d] predictTaken got %b want %b", i, bus.predictTaken, vs[i].ptk); end
      if (bus.predictTarget !== vs[i].ptgt) begin n_fail++; $display("FAIL signed[%0d] predictTarget got %h want %h", i, bus.predictTarget, vs[i].ptgt); end
    end
  endtask

  // Non-branches resolve not-taken and leave index 0 (counter 2, target 0x500) alone.
  task automatic test_non_branch();
    vec_t vs [5];
    vs[0] = '{OP_LW,   32'h0, 32'h0, 32'h200,       32'h900, 1'b1, 1'b1, 1'b0, 32'h204, 32'h40, 1'b1, 32'h500};
    vs[1] = '{OP_LW,   32'h0, 32'h0, 32'hFFFF_FFFC, 32'h900, 1'b1, 1'b1, 1'b0, 32'h0,   32'h40, 1'b1, 32'h500};
    vs[2] = '{OP_RTYP, 32'h7, 32'h7, 32'h40,        32'h900, 1'b0, 1'b0, 1'b0, 32'h0,   32'h40, 1'b1, 32'h500};
    vs[3] = '{OP_JAL,  32'h7, 32'h7, 32'h40,        32'h900, 1'b0, 1'b0, 1'b0, 32'h0,   32'h40, 1'b1, 32'h500};
    vs[4] = '{OP_ADDI, 32'h7, 32'h7, 32'h44,        32'h900, 1'b0, 1'b0, 1'b0, 32'h0,   32'h44, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(vs[i]);
      n_tests += 5;
      if (bus.mispredict !== vs[i].mp) begin n_fail++; $display("FAIL nonbr[%0d] mispredict got %b want %b", i, bus.mispredict, vs[i].mp); end
      if (bus.branchTaken !== vs[i].tk) begin n_fail++; $display("FAIL nonbr[%0d] branchTaken got %b want %b", i, bus.branchTaken, vs[i].tk); end
      if (bus.redirectPC !== vs[i].rd) begin n_fail++; $display("FAIL nonbr[%0d] redirectPC got %h want %h", i, bus.redirectPC, vs[i].rd); end
      if (bus.predictTaken !== vs[i].ptk) begin n_fail++; $display("FAIL nonbr[%0d] predictTaken got %b want %b", i, bus.predictTaken, vs[i].ptk); end
      if (bus.predictTarget !== vs[i].ptgt) begin n_fail++; $display("FAIL nonbr[%0d] predictTarget got %h want %h", i, bus.predictTarget, vs[i].ptgt); end
    end
  endtask

  // Fetch of the index being written in the same cycle sees the old entry.
  task automatic test_collision();
    @(negedge clk);
    bus.fetchPC = 32'h48; bus.resolveValid = 1'b1; bus.opcode = OP_BEQ;
    bus.Da = 32'd7; bus.Db = 32'd7; bus.resolvePC = 32'h48; bus.branchTarget = 32'h700;
    bus.predictedTaken = 1'b0;
    #1;
    n_tests += 2;
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL coll_new_pre predictTaken got %b want 0", bus.predictTaken); end
    if (bus.predictTarget !== 32'h0) begin n_fail++; $display("FAIL coll_new_pre predictTarget got %h want 0", bus.predictTarget); end
    @(posedge clk);
    #1;
    n_tests += 4;
    if (bus.predictTaken !== 1'b1) begin n_fail++; $display("FAIL coll_new_post predictTaken got %b want 1", bus.predictTaken); end
    if (bus.predictTarget !== 32'h700) begin n_fail++; $display("FAIL coll_new_post predictTarget got %h want 700", bus.predictTarget); end
    if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL coll_new_post mispredict got %b want 1", bus.mispredict); end
    if (bus.redirectPC !== 32'h700) begin n_fail++; $display("FAIL coll_new_post redirectPC got %h want 700", bus.redirectPC); end

    // Valid entry 0 (counter 2, target 0x500) weakened to 1 by a not-taken BNE.
    @(negedge clk);
    bus.fetchPC = 32'h40; bus.opcode = OP_BNE; bus.Da = 32'd9; bus.Db = 32'd9;
    bus.resolvePC = 32'h40; bus.branchTarget = 32'h520; bus.predictedTaken = 1'b1;
    #1;
    n_tests += 2;
    if (bus.predictTaken !== 1'b1) begin n_fail++; $display("FAIL coll_old_pre predictTaken got %b want 1", bus.predictTaken); end
    if (bus.predictTarget !== 32'h500) begin n_fail++; $display("FAIL coll_old_pre predictTarget got %h want 500", bus.predictTarget); end
    @(posedge clk);
    #1;
    n_tests += 3;
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL coll_old_post predictTaken got %b want 0", bus.predictTaken); end
    if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL coll_old_post mispredict got %b want 1", bus.mispredict); end
    if (bus.redirectPC !== 32'h44) begin n_fail++; $display("FAIL coll_old_post redirectPC got %h want 44", bus.redirectPC); end
  endtask

  // Consecutive resolves on index 3, then an idle cycle clears the result.
  task automatic test_back_to_back();
    vec_t vs [2];
    vs[0] = '{OP_BEQ, 32'd1, 32'd1, 32'h4C, 32'h800, 1'b1, 1'b0, 1'b1, 32'h0,   32'h4C, 1'b1, 32'h800};
    vs[1] = '{OP_BNE, 32'd1, 32'd2, 32'h4C, 32'h900, 1'b0, 1'b1, 1'b1, 32'h900, 32'h4C, 1'b1, 32'h900};
    for (int i = 0; i < 2; i++) begin
      drive(vs[i]);
      n_tests += 5;
      if (bus.mispredict !== vs[i].mp) begin n_fail++; $display("FAIL b2b[%0d] mispredict got %b want %b", i, bus.mispredict, vs[i].mp); end
      if (bus.branchTaken !== vs[i].tk) begin n_fail++; $display("FAIL b2b[%0d] branchTaken got %b want %b", i, bus.branchTaken, vs[i].tk); end
      if (bus.redirectPC !== vs[i].rd) begin n_fail++; $display("FAIL b2b[%0d] redirectPC got %h want %h", i, bus.redirectPC, vs[i].rd); end
      if (bus.predictTaken !== vs[i].ptk) begin n_fail++; $display("FAIL b2b[%0d] predictTaken got %b want %b", i, bus.predictTaken, vs[i].ptk); end
      if (bus.predictTarget !== vs[i].ptgt) begin n_fail++; $display("FAIL b2b[%0d] predictTarget got %h want %h", i, bus.predictTarget, vs[i].ptgt); end
    end
    idle();
    n_tests += 3;
    if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL b2b_idle mispredict got %b want 0", bus.mispredict); end
    if (bus.branchTaken !== 1'b0) begin n_fail++; $display("FAIL b2b_idle branchTaken got %b want 0", bus.branchTaken); end
    if (bus.redirectPC !== 32'h0) begin n_fail++; $display("FAIL b2b_idle redirectPC got %h want 0", bus.redirectPC); end
  endtask

  // Reset asserted between edges while a mispredict pulse is showing.
  task automatic test_reset_mid();
    vec_t v;
    v = '{OP_BEQ, 32'd3, 32'd3, 32'h40, 32'hA00, 1'b0, 1'b1, 1'b1, 32'hA00, 32'h40, 1'b1, 32'hA00};
    drive(v);
    n_tests += 2;
    if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL rmid_pre mispredict got %b want 1", bus.mispredict); end
    if (bus.predictTaken !== 1'b1) begin n_fail++; $display("FAIL rmid_pre predictTaken got %b want 1", bus.predictTaken); end
    #1 resetN = 1'b0;
    #1;
    n_tests += 7;
    if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL rmid mispredict got %b want 0", bus.mispredict); end
    if (bus.redirectPC !== 32'h0) begin n_fail++; $display("FAIL rmid redirectPC got %h want 0", bus.redirectPC); end
    if (bus.branchTaken !== 1'b0) begin n_fail++; $display("FAIL rmid branchTaken got %b want 0", bus.branchTaken); end
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL rmid predictTaken got %b want 0", bus.predictTaken); end
    if (bus.predictTarget !== 32'h0) begin n_fail++; $display("FAIL rmid predictTarget got %h want 0", bus.predictTarget); end
    if (bus.branchCount !== 32'h0) begin n_fail++; $display("FAIL rmid branchCount got %0d want 0", bus.branchCount); end
    if (bus.mispredictCount !== 32'h0) begin n_fail++; $display("FAIL rmid mispredictCount got %0d want 0", bus.mispredictCount); end
    @(posedge clk);
    #1;
    n_tests += 1;
    if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL rmid_held mispredict got %b want 0", bus.mispredict); end
    @(negedge clk);
    resetN = 1'b1;
    bus.resolveValid = 1'b0;
    bus.fetchPC = 32'h4C;
    #1;
    n_tests += 1;
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL rmid_idx3 predictTaken got %b want 0", bus.predictTaken); end
    @(posedge clk);
    #1;
    n_tests += 1;
    if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL rmid_release mispredict got %b want 0", bus.mispredict); end
  endtask

  // Two branches and one mispredict; counts are 0 when the stats macro is off.
  task automatic test_stats();
    vec_t v;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
`ifdef BRANCH_STATS_EN
    exp_bc = 32'd2;
    exp_mc = 32'd1;
`else
    exp_bc = 32'd0;
    exp_mc = 32'd0;
`endif
    v = '{OP_BEQ, 32'd2, 32'd2, 32'h40, 32'hB00, 1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 1'b1, 32'hB00};
    drive(v);
    v = '{OP_BNE, 32'd2, 32'd2, 32'h40, 32'hB00, 1'b1, 1'b1, 1'b0, 32'h44, 32'h40, 1'b0, 32'h0};
    drive(v);
    v = '{OP_LW, 32'd2, 32'd2, 32'h40, 32'hB00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 32'h0};
    drive(v);
    idle();
    n_tests += 3;
    if (bus.branchCount !== exp_bc) begin n_fail++; $display("FAIL stats branchCount got %0d want %0d", bus.branchCount, exp_bc); end
    if (bus.mispredictCount !== exp_mc) begin n_fail++; $display("FAIL stats mispredictCount got %0d want %0d", bus.mispredictCount, exp_mc); end
    if (bus.predictTaken !== 1'b0) begin n_fail++; $display("FAIL stats predictTaken got %b want 0", bus.predictTaken); end
    #1 resetN = 1'b0;
    #1;
    n_tests += 2;
    if (bus.branchCount !== 32'h0) begin n_fail++; $display("FAIL stats_reset branchCount got %0d want 0", bus.branchCount); end
    if (bus.mispredictCount !== 32'h0) begin n_fail++; $display("FAIL stats_reset mispredictCount got %0d want 0", bus.mispredictCount); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    bus.fetchPC        = '0;
    bus.resolveValid   = 1'b0;
    bus.opcode         = '0;
    bus.Da             = '0;
    bus.Db             = '0;
    bus.resolvePC      = '0;
    bus.branchTarget   = '0;
    bus.predictedTaken = 1'b0;
    test_reset();
    test_beq_counter();
    test_signed();
    test_non_branch();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
